// File: rtl/capture_limiter_pkg.sv
// Shared definitions for the capture step limiter: mode codes, FSM state, mode helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package capture_limiter_pkg;

  localparam logic [1:0] MODE_FREE = 2'd0;
  localparam logic [1:0] MODE_STOP = 2'd1;
  localparam logic [1:0] MODE_WRAP = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_STOPPED = 2'd2
  } state_t;

  // Reserved mode and a zero limit both collapse to free-running counting.
  function automatic logic [1:0] eff_mode(input logic [1:0] mode, input logic limit_nz);
    if ((mode == MODE_STOP || mode == MODE_WRAP) && limit_nz) return mode;
    return MODE_FREE;
  endfunction

endpackage

// File: rtl/capture_limiter_step_prescaler.sv
// Step prescaler: passes one of every prescale+1 enabled step strobes.
// Latency: o_accept is combinational on the current step; counter updates next edge.
// Backpressure: none; steps arriving while disabled are ignored and leave the counter alone.
module step_prescaler #(
  parameter int PRE_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             enable,
  input  logic             i_step,
  input  logic [PRE_W-1:0] prescale,
  output logic             o_accept
);

  logic [PRE_W-1:0] r_cnt;
  logic             w_match;

  assign w_match  = (r_cnt == prescale);
  assign o_accept = enable && i_step && w_match;

  // Count enabled steps, rolling over on the accepted one; a restart zeroes the phase.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (enable && i_step) begin
      r_cnt <= w_match ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/capture_limiter.sv
// Capture step limiter: counts prescaled steps during a run, then stops, wraps or saturates.
// Latency: an accepted step shows on o_count/o_stop/o_done one cycle later.
// Backpressure: none; optional inactivity timeout enabled by CAPTURE_LIMITER_TIMEOUT_EN.
module capture_limiter
  import capture_limiter_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int PRE_W = 8,
  parameter int TMO_W = 16
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_run,
  input  logic             i_step,
  input  logic             i_clear,
  input  logic [1:0]       cfg_mode,
  input  logic [CNT_W-1:0] cfg_limit,
  input  logic [PRE_W-1:0] cfg_prescale,
`ifdef CAPTURE_LIMITER_TIMEOUT_EN
  input  logic [TMO_W-1:0] cfg_timeout,
  output logic             o_timeout,
`endif
  output logic             o_running,
  output logic             o_stop,
  output logic             o_done,
  output logic             o_overflow,
  output logic [CNT_W-1:0] o_count
);

  state_t           r_state, w_state_nxt;
  logic             r_run_q;
  logic [1:0]       r_mode;
  logic [CNT_W-1:0] r_limit;
  logic [PRE_W-1:0] r_prescale;
  logic [CNT_W-1:0] r_count;
  logic             r_done;
  logic             r_overflow;

  logic             w_start;
  logic             w_step_en;
  logic             w_accept;
  logic             w_limited;
  logic             w_hit;
  logic             w_tmo_hit;
  logic [CNT_W-1:0] w_limit_m1;

  // A run starts on a rising run level in IDLE, or restarts on clear once running/stopped.
  assign w_start    = i_run && (((r_state == ST_IDLE) && !r_run_q) ||
                                ((r_state != ST_IDLE) && i_clear));
  // Steps only count in RUN when neither a run drop nor a clear outranks them.
  assign w_step_en  = (r_state == ST_RUN) && i_run && !i_clear;
  assign w_limited  = (eff_mode(r_mode, r_limit != '0) != MODE_FREE);
  assign w_limit_m1 = r_limit - 1'b1;
  assign w_hit      = w_limited && (r_count == w_limit_m1);

  step_prescaler #(.PRE_W(PRE_W)) u_prescaler (
    .clk      (i_clk),
    .reset_n  (i_reset_n),
    .clear    (w_start),
    .enable   (w_step_en),
    .i_step   (i_step),
    .prescale (r_prescale),
    .o_accept (w_accept)
  );

`ifdef CAPTURE_LIMITER_TIMEOUT_EN
  logic [TMO_W-1:0] r_timeout_cfg;
  logic [TMO_W-1:0] r_idle_cnt;
  logic             r_timeout;

  assign w_tmo_hit = w_step_en && !i_step && (r_timeout_cfg != '0) &&
                     ((r_idle_cnt + 1'b1) == r_timeout_cfg);

  // Track step-less cycles in RUN; flag a timeout once the shadowed limit is reached.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_timeout_cfg <= '0;
      r_idle_cnt    <= '0;
      r_timeout     <= 1'b0;
    end else if (w_start) begin
      r_timeout_cfg <= cfg_timeout;
      r_idle_cnt    <= '0;
      r_timeout     <= 1'b0;
    end else if (w_step_en) begin
      r_idle_cnt <= i_step ? '0 : r_idle_cnt + 1'b1;
      if (w_tmo_hit) r_timeout <= 1'b1;
    end
  end

  assign o_timeout = r_timeout;
`else
  assign w_tmo_hit = 1'b0;
  // Keeps the timeout width referenced in builds without the timeout logic.
  if (TMO_W < 1) begin : g_tmo_w_unused
  end
`endif

  // Previous run level, used to detect the run rising edge.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_run_q <= 1'b0;
    else            r_run_q <= i_run;
  end

  // Shadow config is frozen at run start so mid-run edits have no effect.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_mode     <= '0;
      r_limit    <= '0;
      r_prescale <= '0;
    end else if (w_start) begin
      r_mode     <= cfg_mode;
      r_limit    <= cfg_limit;
      r_prescale <= cfg_prescale;
    end
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= ST_IDLE;
    else            r_state <= w_state_nxt;
  end

  // Next state: run drop beats clear, clear beats a limit or timeout stop.
  always_comb begin
    w_state_nxt = r_state;
    if (!i_run) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:    if (!r_run_q) w_state_nxt = ST_RUN;
        ST_RUN: begin
          if (i_clear)
            w_state_nxt = ST_RUN;
          else if ((w_accept && w_hit && (r_mode == MODE_STOP)) || w_tmo_hit)
            w_state_nxt = ST_STOPPED;
        end
        ST_STOPPED: if (i_clear) w_state_nxt = ST_RUN;
        default:    w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Step counter, done pulse and sticky overflow; count and overflow hold through IDLE.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_count    <= '0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_start) begin
        r_count    <= '0;
        r_overflow <= 1'b0;
      end else if (w_accept) begin
        if (w_hit) begin
          r_done  <= 1'b1;
          r_count <= (r_mode == MODE_STOP) ? r_limit : '0;
        end else if (&r_count) begin
          r_overflow <= 1'b1;
        end else begin
          r_count <= r_count + 1'b1;
        end
      end
    end
  end

  assign o_running  = (r_state == ST_RUN);
  assign o_stop     = (r_state == ST_STOPPED);
  assign o_done     = r_done;
  assign o_overflow = r_overflow;
  assign o_count    = r_count;

endmodule

// File: tb/tb_capture_limiter.sv
// Bench for capture_limiter: directed scenarios plus random traffic against a cycle model.
// Latency: checks sample 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_capture_limiter;

  localparam int CNT_W   = 4;
  localparam int PRE_W   = 3;
  localparam int TMO_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             i_reset_n;
  logic             i_run, i_step, i_clear;
  logic [1:0]       cfg_mode;
  logic [CNT_W-1:0] cfg_limit;
  logic [PRE_W-1:0] cfg_prescale;
  logic             o_running, o_stop, o_done, o_overflow;
  logic [CNT_W-1:0] o_count;
`ifdef CAPTURE_LIMITER_TIMEOUT_EN
  logic [TMO_W-1:0] cfg_timeout;
  logic             o_timeout;
`endif

  always #5 clk = ~clk;

  capture_limiter #(.CNT_W(CNT_W), .PRE_W(PRE_W), .TMO_W(TMO_W)) dut (
    .i_clk        (clk),
    .i_reset_n    (i_reset_n),
    .i_run        (i_run),
    .i_step       (i_step),
    .i_clear      (i_clear),
    .cfg_mode     (cfg_mode),
    .cfg_limit    (cfg_limit),
    .cfg_prescale (cfg_prescale),
`ifdef CAPTURE_LIMITER_TIMEOUT_EN
    .cfg_timeout  (cfg_timeout),
    .o_timeout    (o_timeout),
`endif
    .o_running    (o_running),
    .o_stop       (o_stop),
    .o_done       (o_done),
    .o_overflow   (o_overflow),
    .o_count      (o_count)
  );

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Reference model: state 0=idle 1=run 2=stopped, plain integers.
  int m_st, m_runq, m_cnt, m_ovf, m_done, m_pre, m_idle, m_tmo;
  int s_mode, s_lim, s_pre, s_tmo;

  task automatic check(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_runq = 0; m_cnt = 0; m_ovf = 0; m_done = 0; m_pre = 0;
    m_idle = 0; m_tmo = 0; s_mode = 0; s_lim = 0; s_pre = 0; s_tmo = 0;
  endtask

  task automatic model_start();
    s_mode = int'(cfg_mode);
    s_lim  = int'(cfg_limit);
    s_pre  = int'(cfg_prescale);
`ifdef CAPTURE_LIMITER_TIMEOUT_EN
    s_tmo  = int'(cfg_timeout);
`else
    s_tmo  = 0;
`endif
    m_cnt = 0; m_pre = 0; m_ovf = 0; m_idle = 0; m_tmo = 0; m_st = 1;
  endtask

  task automatic model_accept();
    if ((s_mode == 1 || s_mode == 2) && s_lim != 0 && m_cnt == s_lim - 1) begin
      m_done = 1;
      if (s_mode == 1) begin m_cnt = s_lim; m_st = 2; end
      else m_cnt = 0;
    end else if (m_cnt == CNT_MAX) begin
      m_ovf = 1;
    end else begin
      m_cnt = m_cnt + 1;
    end
  endtask

  task automatic model_update(input int run, input int step, input int clr);
    m_done = 0;
    if (run == 0) m_st = 0;
    else if (m_st == 0) begin
      if (m_runq == 0) model_start();
    end else if (clr != 0) model_start();
    else if (m_st == 1) begin
      if (step != 0) begin
        m_idle = 0;
        if (m_pre == s_pre) begin m_pre = 0; model_accept(); end
        else m_pre = m_pre + 1;
      end else begin
        m_idle = (m_idle + 1) % (1 << TMO_W);
        if (s_tmo != 0 && m_idle == s_tmo) begin m_st = 2; m_tmo = 1; end
      end
    end
    m_runq = run;
  endtask

  task automatic check_all();
    check("running",  int'(o_running),  (m_st == 1) ? 1 : 0);
    check("stop",     int'(o_stop),     (m_st == 2) ? 1 : 0);
    check("done",     int'(o_done),     m_done);
    check("overflow", int'(o_overflow), m_ovf);
    check("count",    int'(o_count),    m_cnt);
`ifdef CAPTURE_LIMITER_TIMEOUT_EN
    check("timeout",  int'(o_timeout),  m_tmo);
`endif
  endtask

  task automatic tick(input logic run, input logic step, input logic clr);
    i_run = run; i_step = step; i_clear = clr;
    @(posedge clk);
    model_update(int'(run), int'(step), int'(clr));
    #1;
    check_all();
  endtask

  initial begin
    int done_seen;
    int seq2 [12];
    seq2 = '{0, 1, 1, 2, 2, 0, 0, 1, 1, 2, 2, 0};

    i_reset_n = 1'b0; i_run = 1'b0; i_step = 1'b0; i_clear = 1'b0;
    cfg_mode = 2'd0; cfg_limit = '0; cfg_prescale = '0;
`ifdef CAPTURE_LIMITER_TIMEOUT_EN
    cfg_timeout = '0;
`endif
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_running", int'(o_running), 0);
    check("rst_stop", int'(o_stop), 0);
    check("rst_count", int'(o_count), 0);
    check_all();
    i_reset_n = 1'b1;

    // Mode 1, limit 5, prescale 0, steps spaced two cycles apart.
    cfg_mode = 2'd1; cfg_limit = 4'd5; cfg_prescale = 3'd0;
    tick(1, 0, 0);
    check("m1_running", int'(o_running), 1);
    done_seen = 0;
    for (int i = 1; i <= 5; i++) begin
      tick(1, 1, 0);
      check("m1_count", int'(o_count), i);
      done_seen += int'(o_done);
      if (i == 4) check("m1_stop_early", int'(o_stop), 0);
      tick(1, 0, 0);
      done_seen += int'(o_done);
    end
    check("m1_stop", int'(o_stop), 1);
    check("m1_done_pulses", done_seen, 1);
    tick(1, 1, 0);
    check("m1_sixth_step", int'(o_count), 5);
    tick(0, 0, 0);

    // Mode 2, limit 3, prescale 1, 12 back-to-back steps.
    cfg_mode = 2'd2; cfg_limit = 4'd3; cfg_prescale = 3'd1;
    tick(1, 0, 0);
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1, 1, 0);
      check("m2_count_seq", int'(o_count), seq2[i]);
      check("m2_no_stop", int'(o_stop), 0);
      done_seen += int'(o_done);
    end
    check("m2_done_pulses", done_seen, 2);
    tick(0, 0, 0);

    // Mode 0 saturation: 17 back-to-back steps.
    cfg_mode = 2'd0; cfg_limit = 4'd0; cfg_prescale = 3'd0;
    tick(1, 0, 0);
    for (int i = 1; i <= 17; i++) begin
      tick(1, 1, 0);
      if (i == 15) check("m0_ovf_before", int'(o_overflow), 0);
      if (i == 16) check("m0_ovf_16th", int'(o_overflow), 1);
    end
    check("m0_sat_count", int'(o_count), 15);
    tick(0, 0, 0);
    check("m0_ovf_held", int'(o_overflow), 1);
    check("m0_count_held", int'(o_count), 15);

    // Limit edit mid-run is ignored until clear; clear beats a coincident step.
    cfg_mode = 2'd1; cfg_limit = 4'd4;
    tick(1, 0, 0);
    check("clr_ovf_cleared", int'(o_overflow), 0);
    tick(1, 1, 0);
    tick(1, 1, 0);
    cfg_limit = 4'd2;
    tick(1, 1, 0);
    check("clr_shadow_count", int'(o_count), 3);
    check("clr_shadow_nostop", int'(o_stop), 0);
    tick(1, 1, 1);
    check("clr_count0", int'(o_count), 0);
    tick(1, 1, 0);
    tick(1, 1, 0);
    check("clr_new_limit", int'(o_count), 2);
    check("clr_new_stop", int'(o_stop), 1);
    tick(0, 0, 0);

    // Stop at 3, drop run, raise again.
    cfg_limit = 4'd3;
    tick(1, 0, 0);
    repeat (3) tick(1, 1, 0);
    check("rerun_stop", int'(o_stop), 1);
    tick(0, 0, 0);
    check("rerun_idle_stop", int'(o_stop), 0);
    check("rerun_held_count", int'(o_count), 3);
    tick(1, 0, 0);
    check("rerun_count0", int'(o_count), 0);
    check("rerun_running", int'(o_running), 1);

    // Asynchronous reset mid-run with count 7.
    cfg_mode = 2'd0;
    tick(1, 1, 1);
    repeat (7) tick(1, 1, 0);
    check("arst_pre_count", int'(o_count), 7);
    i_reset_n = 1'b0;
    #1;
    check("arst_count", int'(o_count), 0);
    check("arst_running", int'(o_running), 0);
    check("arst_stop", int'(o_stop), 0);
    @(posedge clk);
    #1;
    i_reset_n = 1'b1;
    model_reset();
    tick(0, 0, 0);

`ifdef CAPTURE_LIMITER_TIMEOUT_EN
    // Inactivity timeout of 10 cycles.
    cfg_timeout = 8'd10;
    tick(1, 0, 0);
    for (int i = 1; i <= 10; i++) begin
      tick(1, 0, 0);
      if (i == 9) check("tmo_not_yet", int'(o_stop), 0);
    end
    check("tmo_flag", int'(o_timeout), 1);
    check("tmo_stop", int'(o_stop), 1);
    check("tmo_no_done", int'(o_done), 0);
    tick(0, 0, 0);
    cfg_timeout = '0;
`endif

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        cfg_mode     = 2'($urandom_range(0, 3));
        cfg_limit    = CNT_W'($urandom_range(0, CNT_MAX));
        cfg_prescale = PRE_W'($urandom_range(0, 3));
`ifdef CAPTURE_LIMITER_TIMEOUT_EN
        cfg_timeout  = ($urandom_range(0, 2) == 0) ? TMO_W'($urandom_range(3, 12)) : '0;
`endif
      end
      tick(logic'($urandom_range(0, 15) != 0), logic'($urandom_range(0, 1)),
           logic'($urandom_range(0, 24) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/capture_limiter.md
Name: capture_limiter

Overview:
Parametrised, fully synchronous successor to the step-count stop logic in the logic analyser capture path. It counts accepted sample steps while a run is active, optionally through a prescaler. It then stops, wraps or saturates according to a run-time mode. The sampler consumes o_stop and o_running; the host interface reads o_count and the status flags.

Parameters:
CNT_W, 32, width of step counter and limit
PRE_W, 8, width of step prescaler and its config
TMO_W, 16, width of the inactivity timeout counter (used only with the optional feature)

Ports:
i_clk  in  1  system clock; all logic on its rising edge
i_reset_n  in  1  asynchronous active-low reset
i_run  in  1  run request level from the control register
i_step  in  1  one-cycle strobe per captured sample
i_clear  in  1  synchronous restart strobe
cfg_mode  in  2  0=free-run, 1=limit-and-stop, 2=limit-and-wrap, 3=reserved (treated as 0)
cfg_limit  in  CNT_W  number of accepted steps per run or period
cfg_prescale  in  PRE_W  accept one of every cfg_prescale+1 steps
o_running  out  1  high in RUN
o_stop  out  1  high in STOPPED
o_done  out  1  one-cycle pulse when limit reached (modes 1, 2)
o_overflow  out  1  sticky; counter saturated in mode 0
o_count  out  CNT_W  accepted steps in the current run or period

Behaviour:
- Clock and reset: one clock, i_clk. Reset is asynchronous and active-low on i_reset_n.
- Values while i_reset_n is low: state IDLE; all outputs 0; shadow config 0; prescaler 0.
- States:
  - IDLE: entered from reset or when i_run is low. Leaves on a rising edge of i_run (registered i_run was 0, current i_run is 1) -> RUN.
  - RUN: counts accepted steps.
  - STOPPED: held until i_run is low (-> IDLE) or i_clear (-> RUN).
- Config capture: on IDLE->RUN and on every i_clear, cfg_* is latched into shadow registers, and o_count, the prescaler and o_overflow are zeroed. Config changes mid-run have no effect.
- Step acceptance: a step is accepted when i_step is high in RUN and the prescaler equals the shadow prescale. The prescaler then resets to 0; otherwise it increments on each i_step.
- Latency: an accepted step in cycle N is visible on o_count in cycle N+1. Any resulting o_stop or o_done is also asserted in cycle N+1.
- Limit reached: an accepted step arrives while o_count == limit-1.
  - Mode 1: o_count becomes limit, state -> STOPPED, o_done pulses.
  - Mode 2: o_count becomes 0, o_done pulses, state stays RUN.
  - Mode 0: no limit. o_count saturates at all-ones and o_overflow sets on the step that would wrap it.
- Shadow limit == 0 in modes 1 and 2: behaves as mode 0.
- i_run low in any state -> IDLE next cycle, o_stop and o_running cleared. o_count and o_overflow are held for readout until the next run start.
- Priority within a cycle, highest first: i_run low, then i_clear, then step. A step coinciding with i_clear or a run drop is discarded.
- i_clear in IDLE is ignored.
- i_step outside RUN is ignored and the prescaler is untouched.
- Reset asserted mid-run: immediate asynchronous return to IDLE with all outputs 0.

Optional Feature:
CAPTURE_LIMITER_TIMEOUT_EN
- Defined:
  - Adds input cfg_timeout[TMO_W] (shadowed like other config) and output o_timeout (sticky, cleared on run start or i_clear).
  - In RUN, a cycle counter resets on every i_step and otherwise increments.
  - When it reaches a nonzero shadow timeout: state -> STOPPED, o_timeout=1, o_done not pulsed.
  - Shadow timeout 0 disables the timeout.
- Undefined: the port and logic are absent, and behaviour is exactly as above.

Decomposition:
- Package capture_limiter_pkg:
  - mode constants MODE_FREE, MODE_STOP, MODE_WRAP
  - state encoding IDLE/RUN/STOPPED as a 2-bit typedef
- Sub-module step_prescaler:
  - ports: clk, reset_n, clear, enable, i_step, prescale, o_accept
  - instantiated once; owns the prescaler counter and the accept decision.
- The FSM, counter and timeout stay in capture_limiter.

Test Plan:
- Mode 1, limit=5, prescale=0, 5 steps spaced 2 cycles apart -> o_count 1..5; o_stop rises the cycle after the 5th step; one o_done pulse; a 6th step leaves o_count=5.
- Mode 2, limit=3, prescale=1, 12 steps -> 6 accepted; o_count sequence 1,2,0,1,2,0; o_done pulses twice; o_stop never set.
- Mode 0, CNT_W=4, 17 back-to-back steps -> o_count holds at 15; o_overflow set on the 16th step and held after i_run drops.
- Limit=4, change cfg_limit to 2 mid-run, then i_clear together with a step -> clear wins and o_count=0; a new run then stops at 2 after re-sampling.
- Stopped at limit 3, drop i_run, raise again -> IDLE clears o_stop with o_count held at 3; on re-run o_count=0 and o_running=1.
- Pulse i_reset_n low for 1 cycle mid-run with o_count=7 -> all outputs 0 asynchronously. With CAPTURE_LIMITER_TIMEOUT_EN and timeout=10: no steps for 10 cycles -> o_timeout=1 and o_stop=1.
